// File: rtl/fwd_bypass_net.sv
// Operand-forwarding network: tracks DEPTH in-flight register writes and resolves
// NSRC source operands against them, youngest producer first, flagging load-use hazards.
module fwd_bypass_net #(
    parameter int XLEN       = 32,
    parameter int AREG       = 5,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int FILL_STAGE = 1,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   wr_valid_i,
    input  logic [AREG-1:0]        wr_addr_i,
    input  logic [XLEN-1:0]        wr_data_i,
    input  logic                   wr_ready_i,
    input  logic                   fill_valid_i,
    input  logic [XLEN-1:0]        fill_data_i,
    input  logic [NSRC*AREG-1:0]   src_addr_i,
    input  logic [NSRC*XLEN-1:0]   rf_data_i,
    output logic [NSRC*XLEN-1:0]   opnd_o,
    output logic [NSRC*SELW-1:0]   fwd_sel_o,
    output logic                   hazard_o,
    output logic [15:0]            hazard_cnt_o
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_ready;
    logic [AREG-1:0]  r_addr [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [15:0]      r_hazardCnt;

    logic             w_fillHit;
    logic [NSRC*XLEN-1:0] w_opnd;
    logic [NSRC*SELW-1:0] w_sel;
    logic [NSRC-1:0]      w_hazVec;

    // A fill only lands on a load that is still waiting for its data.
    assign w_fillHit = fill_valid_i && r_valid[FILL_STAGE] && !r_ready[FILL_STAGE];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_valid[j] <= 1'b0;
                r_ready[j] <= 1'b0;
                r_addr[j]  <= '0;
                r_data[j]  <= '0;
            end
            r_hazardCnt <= '0;
        end else begin
            if (!stall_i) begin
                r_valid[0] <= wr_valid_i && (wr_addr_i != '0);
                r_ready[0] <= wr_ready_i;
                r_addr[0]  <= wr_addr_i;
                r_data[0]  <= wr_ready_i ? wr_data_i : '0;
                // A fill coinciding with a shift follows its entry one slot older.
                for (int j = 1; j < DEPTH; j++) begin
                    r_valid[j] <= r_valid[j-1];
                    r_addr[j]  <= r_addr[j-1];
                    if (w_fillHit && (j == FILL_STAGE + 1)) begin
                        r_ready[j] <= 1'b1;
                        r_data[j]  <= fill_data_i;
                    end else begin
                        r_ready[j] <= r_ready[j-1];
                        r_data[j]  <= r_data[j-1];
                    end
                end
            end else if (w_fillHit) begin
                r_ready[FILL_STAGE] <= 1'b1;
                r_data[FILL_STAGE]  <= fill_data_i;
            end
            if (hazard_o && (r_hazardCnt != 16'hFFFF)) begin
                r_hazardCnt <= r_hazardCnt + 16'd1;
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        w_opnd   = '0;
        w_sel    = '0;
        w_hazVec = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_addr_i[k*AREG +: AREG] != '0) begin
                w_opnd[k*XLEN +: XLEN] = rf_data_i[k*XLEN +: XLEN];
                for (int j = DEPTH - 1; j >= 0; j--) begin
                    if (r_valid[j] && (r_addr[j] == src_addr_i[k*AREG +: AREG])) begin
                        w_sel[k*SELW +: SELW]  = SELW'(j + 1);
                        w_opnd[k*XLEN +: XLEN] = r_ready[j] ? r_data[j] : rf_data_i[k*XLEN +: XLEN];
                        w_hazVec[k]            = !r_ready[j];
                    end
                end
            end
        end
    end

    assign opnd_o       = w_opnd;
    assign fwd_sel_o    = w_sel;
    assign hazard_o     = |w_hazVec;
    assign hazard_cnt_o = r_hazardCnt;

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed bench for fwd_bypass_net with hand-computed expectations (DEPTH=3, FILL_STAGE=1).
module tb_fwd_bypass_net;

    localparam int XLEN  = 32;
    localparam int AREG  = 5;
    localparam int DEPTH = 3;
    localparam int NSRC  = 2;
    localparam int SELW  = $clog2(DEPTH + 1);

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 stall_i;
    logic                 wr_valid_i;
    logic [AREG-1:0]      wr_addr_i;
    logic [XLEN-1:0]      wr_data_i;
    logic                 wr_ready_i;
    logic                 fill_valid_i;
    logic [XLEN-1:0]      fill_data_i;
    logic [NSRC*AREG-1:0] src_addr_i;
    logic [NSRC*XLEN-1:0] rf_data_i;
    logic [NSRC*XLEN-1:0] opnd_o;
    logic [NSRC*SELW-1:0] fwd_sel_o;
    logic                 hazard_o;
    logic [15:0]          hazard_cnt_o;

    int errorCount = 0;
    int checkCount = 0;

    fwd_bypass_net #(
        .XLEN(XLEN), .AREG(AREG), .DEPTH(DEPTH), .NSRC(NSRC), .FILL_STAGE(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ready_i(wr_ready_i), .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i),
        .src_addr_i(src_addr_i), .rf_data_i(rf_data_i), .opnd_o(opnd_o),
        .fwd_sel_o(fwd_sel_o), .hazard_o(hazard_o), .hazard_cnt_o(hazard_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge, leaving inputs stable a little after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [AREG-1:0] a, input logic [XLEN-1:0] d, input logic rdy);
        wr_valid_i = v;
        wr_addr_i  = a;
        wr_data_i  = d;
        wr_ready_i = rdy;
    endtask

    task automatic setSrc(input int k, input logic [AREG-1:0] a, input logic [XLEN-1:0] rf);
        src_addr_i[k*AREG +: AREG] = a;
        rf_data_i[k*XLEN +: XLEN]  = rf;
        #1;
    endtask

    function automatic logic [XLEN-1:0] opnd(input int k);
        return opnd_o[k*XLEN +: XLEN];
    endfunction

    function automatic logic [SELW-1:0] sel(input int k);
        return fwd_sel_o[k*SELW +: SELW];
    endfunction

    initial begin
        rst_i        = 1'b0;
        stall_i      = 1'b0;
        fill_valid_i = 1'b0;
        fill_data_i  = '0;
        src_addr_i   = '0;
        rf_data_i    = '0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (3) tick();
        rst_i = 1'b1;
        tick();

        // Reset: a tracked write is dropped by an asynchronous reset mid-cycle.
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b1);
        tick();
        setSrc(0, 5'd5, 32'hAAAA);
        checkOutput("pre_reset_opnd", opnd(0), 32'h55);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("reset_opnd", opnd(0), 32'hAAAA);
        checkOutput("reset_sel", sel(0), 0);
        checkOutput("reset_cnt", hazard_cnt_o, 0);
        checkOutput("reset_haz", hazard_o, 0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst_i = 1'b1;
        tick();

        // Priority: youngest write to x5 wins, then ages out to regfile.
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd5, 32'h22, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        setSrc(0, 5'd5, 32'hAAAA);
        checkOutput("prio_opnd", opnd(0), 32'h22);
        checkOutput("prio_sel", sel(0), 1);
        tick();
        checkOutput("age1_opnd", opnd(0), 32'h22);
        checkOutput("age1_sel", sel(0), 2);
        tick();
        checkOutput("age2_opnd", opnd(0), 32'h22);
        checkOutput("age2_sel", sel(0), 3);
        tick();
        checkOutput("retire_opnd", opnd(0), 32'hAAAA);
        checkOutput("retire_sel", sel(0), 0);

        // x0 never forwards.
        applyStimulus(1'b1, 5'd0, 32'h99, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        setSrc(0, 5'd0, 32'h1);
        checkOutput("x0_opnd", opnd(0), 0);
        checkOutput("x0_sel", sel(0), 0);
        checkOutput("x0_haz", hazard_o, 0);

        // Load-use hazard, stall, then fill at entry 1.
        checkOutput("cnt_before_load", hazard_cnt_o, 0);
        applyStimulus(1'b1, 5'd7, 32'h777, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        setSrc(0, 5'd7, 32'h5555);
        checkOutput("load_haz", hazard_o, 1);
        checkOutput("load_sel", sel(0), 1);
        checkOutput("load_opnd", opnd(0), 32'h5555);
        stall_i = 1'b1;
        tick();
        checkOutput("stall_haz", hazard_o, 1);
        checkOutput("stall_sel", sel(0), 1);
        stall_i = 1'b0;
        tick();
        checkOutput("shift_sel", sel(0), 2);
        stall_i      = 1'b1;
        fill_valid_i = 1'b1;
        fill_data_i  = 32'h1234;
        #1;
        checkOutput("no_bypass_haz", hazard_o, 1);
        checkOutput("no_bypass_opnd", opnd(0), 32'h5555);
        tick();
        fill_valid_i = 1'b0;
        stall_i      = 1'b0;
        #1;
        checkOutput("fill_opnd", opnd(0), 32'h1234);
        checkOutput("fill_sel", sel(0), 2);
        checkOutput("fill_haz", hazard_o, 0);
        checkOutput("fill_cnt", hazard_cnt_o, 3);

        // Fill and shift in the same cycle: data follows the entry to slot 2.
        setSrc(0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd8, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        tick();
        setSrc(0, 5'd8, 32'h6666);
        checkOutput("x8_haz", hazard_o, 1);
        checkOutput("x8_sel", sel(0), 2);
        fill_valid_i = 1'b1;
        fill_data_i  = 32'hBEEF;
        tick();
        fill_valid_i = 1'b0;
        #1;
        checkOutput("fillshift_opnd", opnd(0), 32'hBEEF);
        checkOutput("fillshift_sel", sel(0), 3);
        checkOutput("fillshift_haz", hazard_o, 0);
        checkOutput("fillshift_cnt", hazard_cnt_o, 4);

        // Saturation of the hazard counter under a long stall.
        setSrc(0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd9, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        setSrc(0, 5'd9, 32'h0);
        stall_i = 1'b1;
        repeat (100) tick();
        checkOutput("cnt_104", hazard_cnt_o, 104);
        repeat (70000) @(posedge clk_i);
        #1;
        checkOutput("cnt_sat", hazard_cnt_o, 16'hFFFF);
        checkOutput("sat_haz", hazard_o, 1);
        stall_i = 1'b0;
        setSrc(0, 5'd0, 32'h0);

        // Both sources forwarding from the same producer.
        applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        setSrc(0, 5'd3, 32'hA0A0);
        setSrc(1, 5'd3, 32'hB0B0);
        checkOutput("dual_opnd0", opnd(0), 32'h3333);
        checkOutput("dual_opnd1", opnd(1), 32'h3333);
        checkOutput("dual_sel0", sel(0), 1);
        checkOutput("dual_sel1", sel(1), 1);
        checkOutput("dual_haz", hazard_o, 0);
        checkOutput("dual_cnt", hazard_cnt_o, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
